// File: rtl/mse_pkg.sv
// mse_pkg: shared types and width constants for the MSE metric block.
//   mse_state_e : FSM state encoding (IDLE, ACC, DRAIN, DONE)
//   DW_DEF, LOG2_WIN_DEF : default sample width and window exponent
//   DIFF_W, SQ_W, ACC_W  : widths at the default parameters
//   diff_w/sq_w/acc_w    : the same widths for arbitrary parameters
package mse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mse_state_e;

  localparam int DW_DEF       = 16;
  localparam int LOG2_WIN_DEF = 10;

  localparam int DIFF_W = DW_DEF + 1;
  localparam int SQ_W   = 2 * DW_DEF;
  localparam int ACC_W  = SQ_W + LOG2_WIN_DEF;

  function automatic int diff_w(input int dw);
    return dw + 1;
  endfunction

  function automatic int sq_w(input int dw);
    return 2 * dw;
  endfunction

  function automatic int acc_w(input int dw, input int log2_win);
    return 2 * dw + log2_win;
  endfunction

endpackage

// File: rtl/mse_sq_stage.sv
// mse_sq_stage: two-stage subtract/square pipeline.
//   stage 1 registers diff = y_ref - y_apx (DW+1 bits, signed)
//   stage 2 registers diff*diff (2*DW bits, unsigned, exact)
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid_i        a pair is accepted this cycle
//   y_ref_i, y_apx_i  signed samples
//   busy_o            any stage holds valid data
//   sq_valid_o, sq_o  squared error out of stage 2
//   absd_o            |diff| aligned with sq_o (only with MSE_MAXERR_EN)
module mse_sq_stage
  import mse_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  input  logic signed [DW-1:0] y_ref_i,
  input  logic signed [DW-1:0] y_apx_i,
  output logic                 busy_o,
  output logic                 sq_valid_o,
  output logic [2*DW-1:0]      sq_o
`ifdef MSE_MAXERR_EN
  ,
  output logic [DW:0]          absd_o
`endif
);

  localparam int DIFF_WL = diff_w(DW);
  localparam int SQ_WL   = sq_w(DW);

  logic signed [DIFF_WL-1:0] diff_d, diff_q;
  logic                      s1_valid_q;
  logic [DW-1:0]             mag;
  logic [SQ_WL-1:0]          sq_d, sq_q;
  logic                      s2_valid_q;
`ifdef MSE_MAXERR_EN
  logic [DW:0]               absd_q;
`endif

  // Sign-extend both operands by one bit so the difference cannot overflow.
  assign diff_d = {y_ref_i[DW-1], y_ref_i} - {y_apx_i[DW-1], y_apx_i};

  // |diff| never exceeds 2^DW-1, so the magnitude fits DW bits and the
  // square of it fits exactly in 2*DW bits.
  assign mag  = diff_q[DIFF_WL-1] ? DW'(-diff_q) : DW'(diff_q);
  assign sq_d = SQ_WL'(mag) * SQ_WL'(mag);

  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q     <= '0;
      s1_valid_q <= 1'b0;
      sq_q       <= '0;
      s2_valid_q <= 1'b0;
`ifdef MSE_MAXERR_EN
      absd_q     <= '0;
`endif
    end else begin
      s1_valid_q <= in_valid_i;
      if (in_valid_i) diff_q <= diff_d;
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sq_q   <= sq_d;
`ifdef MSE_MAXERR_EN
        absd_q <= {1'b0, mag};
`endif
      end
    end
  end

  assign busy_o     = s1_valid_q | s2_valid_q;
  assign sq_valid_o = s2_valid_q;
  assign sq_o       = sq_q;
`ifdef MSE_MAXERR_EN
  assign absd_o     = absd_q;
`endif

endmodule

// File: rtl/mse_metric.sv
// mse_metric: mean squared error between an exact and an approximate filter
// output over a window of 2^LOG2_WIN accepted samples.
// Optional feature macro: MSE_MAXERR_EN adds the max_err output (largest
// |y_ref-y_apx| seen in the window), latched together with mse.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             pulse that opens a window (honoured only in IDLE)
//   in_valid/in_ready handshake for the y_ref/y_apx pair
//   y_ref, y_apx      signed samples
//   mse, mse_valid    result of the last window and its update pulse
//   busy              block is not IDLE
//   max_err           (MSE_MAXERR_EN only) peak |diff| of the last window
//
// state | meaning
// IDLE  | waiting for start, mse holds the last result
// ACC   | accepting pairs until the window count is reached
// DRAIN | waiting for the subtract/square/accumulate pipeline to empty
// DONE  | load mse, pulse mse_valid, go back to IDLE
module mse_metric
  import mse_pkg::*;
#(
  parameter int LOG2_WIN = LOG2_WIN_DEF,
  parameter int DW       = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] y_ref,
  input  logic signed [DW-1:0] y_apx,
  output logic [2*DW-1:0]      mse,
  output logic                 mse_valid,
  output logic                 busy
`ifdef MSE_MAXERR_EN
  ,
  output logic [DW:0]          max_err
`endif
);

  localparam int SQ_WL  = sq_w(DW);
  localparam int ACC_WL = acc_w(DW, LOG2_WIN);

  mse_state_e          state_q;
  logic [LOG2_WIN-1:0] cnt_q;
  logic [ACC_WL-1:0]   acc_q;
  logic [SQ_WL-1:0]    mse_q;
  logic                mse_valid_q;
  logic                accept;
  logic                pipe_busy;
  logic                sq_valid;
  logic [SQ_WL-1:0]    sq;
`ifdef MSE_MAXERR_EN
  logic [DW:0]         absd;
  logic [DW:0]         run_max_q;
  logic [DW:0]         max_err_q;
`endif

  assign in_ready = (state_q == ACC);
  assign busy     = (state_q != IDLE);
  assign accept   = in_valid & in_ready;

  mse_sq_stage #(.DW(DW)) u_sq (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (accept),
    .y_ref_i    (y_ref),
    .y_apx_i    (y_apx),
    .busy_o     (pipe_busy),
    .sq_valid_o (sq_valid),
    .sq_o       (sq)
`ifdef MSE_MAXERR_EN
    ,
    .absd_o     (absd)
`endif
  );

  // The counter is loaded with WIN-1 and counts accepted pairs down; the pair
  // accepted at terminal count zero is the last of the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mse_q       <= '0;
      mse_valid_q <= 1'b0;
`ifdef MSE_MAXERR_EN
      run_max_q   <= '0;
      max_err_q   <= '0;
`endif
    end else begin
      mse_valid_q <= 1'b0;
      if (sq_valid) begin
        acc_q <= acc_q + ACC_WL'(sq);
`ifdef MSE_MAXERR_EN
        if (absd > run_max_q) run_max_q <= absd;
`endif
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= ACC;
            cnt_q     <= '1;
            acc_q     <= '0;
`ifdef MSE_MAXERR_EN
            run_max_q <= '0;
            max_err_q <= '0;
`endif
          end
        end
        ACC: begin
          if (accept) begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!pipe_busy) state_q <= DONE;
        end
        DONE: begin
          // The window sum is below 2^LOG2_WIN * 2^SQ_W, so the quotient fits.
          mse_q       <= SQ_WL'(acc_q >> LOG2_WIN);
          mse_valid_q <= 1'b1;
`ifdef MSE_MAXERR_EN
          max_err_q   <= run_max_q;
`endif
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mse       = mse_q;
  assign mse_valid = mse_valid_q;
`ifdef MSE_MAXERR_EN
  assign max_err   = max_err_q;
`endif

endmodule

// File: tb/tb_mse_metric.sv
// tb_mse_metric: directed bench for mse_metric with LOG2_WIN=2, DW=16.
// max_err is connected and checked only when MSE_MAXERR_EN is defined.
module tb_mse_metric;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] y_ref;
  logic signed [15:0] y_apx;
  logic [31:0]        mse;
  logic               mse_valid;
  logic               busy;
`ifdef MSE_MAXERR_EN
  logic [16:0]        max_err;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mse_metric #(.LOG2_WIN(2), .DW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_ref     (y_ref),
    .y_apx     (y_apx),
    .mse       (mse),
    .mse_valid (mse_valid),
    .busy      (busy)
`ifdef MSE_MAXERR_EN
    ,
    .max_err   (max_err)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_max(input string tag, input int exp);
`ifdef MSE_MAXERR_EN
    chk(tag, 64'(max_err), 64'(exp));
`endif
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int r, input int a);
    in_valid = 1'b1;
    y_ref    = 16'(r);
    y_apx    = 16'(a);
    chk("in_ready_at_accept", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Idle cycle with garbage on the data bus; must not be counted.
  task automatic gap;
    in_valid = 1'b0;
    y_ref    = 16'sd1000;
    y_apx    = -16'sd1000;
    step();
  endtask

  task automatic pulse_start;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called right after the final accept edge; n0 edges already elapsed.
  task automatic wait_result(input string tag, input int n0);
    int n;
    n = n0;
    while (!mse_valid && n < 12) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd4);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; y_ref = '0; y_apx = '0;
    step(); step();
    chk("rst_mse", 64'(mse), 64'd0);
    chk("rst_mse_valid", 64'(mse_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk_max("rst_max_err", 0);
    rst = 1'b0;
    step();
    chk("idle_busy", 64'(busy), 64'd0);

    // Basic window: diffs 2,-2,0,4 -> (4+4+0+16)/4 = 6
    pulse_start();
    chk("acc_busy", 64'(busy), 64'd1);
    send(100, 98); send(100, 102); send(100, 100); send(100, 96);
    chk("drain_in_ready", 64'(in_ready), 64'd0);
    chk("drain_busy", 64'(busy), 64'd1);
    wait_result("basic", 0);
    chk("basic_mse", 64'(mse), 64'd6);
    chk_max("basic_max_err", 4);

    // start in the same cycle as mse_valid is taken on the following IDLE cycle
    pulse_start();
    chk("basic_single_pulse", 64'(mse_valid), 64'd0);
    chk("b2b_start_in_ready", 64'(in_ready), 64'd1);
    chk("hold_mse_next_window", 64'(mse), 64'd6);

    // Full-scale diffs: 65535^2 = 0xFFFE0001 each, sum 4x that
    for (int i = 0; i < 4; i++) send(32767, -32768);
    wait_result("fullscale", 0);
    chk("fullscale_mse", 64'(mse), 64'hFFFE0001);
    chk_max("fullscale_max_err", 65535);
    step();
    chk("fullscale_single_pulse", 64'(mse_valid), 64'd0);
    chk("fullscale_idle_busy", 64'(busy), 64'd0);
    step(); step();
    chk("hold_mse_idle", 64'(mse), 64'hFFFE0001);

    // Identical streams
    pulse_start();
    send(5, 5); send(-7, -7); send(300, 300); send(-32768, -32768);
    wait_result("zero", 0);
    chk("zero_mse", 64'(mse), 64'd0);
    chk_max("zero_max_err", 0);

    // Gapped stream 1,0,0,1,1,0,1: diffs 3,0,-5,-1 -> 35/4 = 8
    pulse_start();
    send(10, 7); gap(); gap();
    chk("gap_in_ready", 64'(in_ready), 64'd1);
    send(20, 20); send(30, 35); gap();
    chk("gap_busy", 64'(busy), 64'd1);
    send(40, 41);
    wait_result("gapped", 0);
    chk("gapped_mse", 64'(mse), 64'd8);
    chk_max("gapped_max_err", 5);

    // Same pairs back-to-back must agree
    step();
    pulse_start();
    send(10, 7); send(20, 20); send(30, 35); send(40, 41);
    wait_result("b2b", 0);
    chk("b2b_mse", 64'(mse), 64'd8);

    // Reset mid-window, then a fresh window of diffs 1,1,1,1
    step();
    pulse_start();
    send(1000, 0); send(-1000, 1000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_mse", 64'(mse), 64'd0);
    chk_max("midrst_max_err", 0);
    step(); step(); step();
    chk("midrst_no_valid", 64'(mse_valid), 64'd0);
    pulse_start();
    send(1, 0); send(2, 1); send(3, 2); send(4, 3);
    wait_result("postrst", 0);
    chk("postrst_mse", 64'(mse), 64'd1);
    chk_max("postrst_max_err", 1);

    // start during ACC and DRAIN ignored: diffs 2,4,6,8 -> 120/4 = 30
    step();
    pulse_start();
    send(2, 0); send(4, 0);
    pulse_start();
    chk("ign_acc_in_ready", 64'(in_ready), 64'd1);
    send(6, 0); send(8, 0);
    pulse_start();
    chk("ign_drain_in_ready", 64'(in_ready), 64'd0);
    wait_result("ignore", 1);
    chk("ignore_mse", 64'(mse), 64'd30);
    chk_max("ignore_max_err", 8);
    step();
    chk("ignore_idle_after", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
